fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the RV32 core. It sits directly upstream of the main opcode controller.
- Holds the PC and runs a request/response handshake with instruction memory.
- Presents one captured instruction and its opcode field to decode/control. It holds them until the execute side acknowledges retirement.
- On retirement it advances the PC, either sequentially (PC+4) or to a redirect target computed downstream for branch, jal, jalr or auipc-based jumps.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset. Must be word-aligned; a misaligned value faults immediately after reset.
- NOP_INSTR, 32'h0000_0013, instruction word driven on instr_o while no valid instruction is held (addi x0,x0,0).

Ports:
- clk_i  input  1  core clock, all state updates on rising edge
- rst_ni  input  1  synchronous active-low reset
- imem_req_o  output  1  fetch request valid
- imem_addr_o  output  32  fetch byte address, equal to pc_o while imem_req_o=1
- imem_ready_i  input  1  memory accepts request this cycle
- imem_rvalid_i  input  1  read data valid
- imem_rdata_i  input  32  instruction word
- instr_valid_o  output  1  instr_o/opcode_o/pc_o describe a held instruction
- instr_o  output  32  held instruction word
- opcode_o  output  7  instr_o[6:0], feeds controller opcode_i
- pc_o  output  32  address of held instruction
- pc_plus4_o  output  32  pc_o + 4, mod 2^32 (jal/jalr link value)
- instr_ack_i  input  1  execute side retires held instruction this cycle
- redirect_i  input  1  next PC is redirect_target_i; sampled only with instr_ack_i
- redirect_target_i  input  32  branch/jump target
- fault_o  output  1  sticky misaligned-fetch fault
- instret_o  output  32  retired-instruction counter

Behaviour:
- Reset (rst_ni=0 at clock edge) wins over all other inputs. It applies these values:
  - state=BOOT, pc_o=RESET_PC, imem_req_o=0, instr_valid_o=0
  - instr_o=NOP_INSTR, opcode_o=7'b0010011
  - fault_o=0, instret_o=0
- Reset mid-operation abandons any outstanding request. The memory is reset on the same rst_ni, and a stale response is never captured.
- FSM states are BOOT, REQ, WAIT, HOLD and FAULT.
- BOOT: lasts one cycle, then moves to REQ, or to FAULT if RESET_PC[1:0]!=0.
- REQ: imem_req_o=1 and imem_addr_o=pc_o, both held stable until imem_ready_i=1. The cycle with imem_req_o=1 and imem_ready_i=1 is the handshake; the state then moves to WAIT and imem_req_o drops next cycle.
- WAIT: imem_req_o=0. On imem_rvalid_i=1:
  - instr_o is loaded with imem_rdata_i
  - the state moves to HOLD, and instr_valid_o=1 from the next cycle
  - imem_rvalid_i is ignored in every state except WAIT.
- Minimum latency: handshake in cycle N, rvalid no earlier than N+1, instr_valid_o in N+2.
- HOLD: instr_o, opcode_o and pc_o stay stable while instr_ack_i=0. redirect_i without instr_ack_i is ignored.
- HOLD with instr_ack_i=1, at that edge:
  - instr_valid_o goes to 0
  - instret_o increments by 1, wrapping 32'hFFFF_FFFF to 0
  - next PC = redirect_i ? redirect_target_i : pc_o+4, with wrap 32'hFFFF_FFFC+4 = 0
  - the new PC goes to REQ if next PC[1:0]==0, otherwise to FAULT.
- FAULT:
  - fault_o=1, imem_req_o=0, instr_valid_o=0
  - pc_o holds the offending target
  - the state is left only by reset.
- Throughput: at most one instruction per 3 cycles with zero-wait memory. There is no prefetch or speculation.
- opcode_o is always instr_o[6:0]. instr_o returns to NOP_INSTR on ack; it is not retained.
- pc_plus4_o is combinational from pc_o.

Test Plan:
- Reset release, RESET_PC=0, memory with imem_ready_i=1 and rvalid one cycle later:
  - BOOT lasts 1 cycle, then imem_req_o=1 with imem_addr_o=0
  - instr_valid_o=1 two cycles after the handshake, with instr_o equal to memory[0] and opcode_o=instr_o[6:0].
- Sequential run of 4 instructions, each acked the cycle it becomes valid:
  - pc_o=0,4,8,C
  - instret_o=4 afterwards
  - imem_addr_o is never changed while imem_req_o=1 and imem_ready_i=0, including a 3-cycle backpressure stall.
- Hold then redirect:
  - instr_valid_o stays 1 for 5 cycles with instr_ack_i=0 and redirect_i=1 toggling; pc_o does not change.
  - Then ack with redirect_i=1 and target 32'h0000_0100: the next request address is 0x100 and pc_plus4_o is 0x104.
- Misaligned redirect target 32'h0000_0102 with ack:
  - fault_o=1 next cycle and stays 1 for 20 cycles
  - imem_req_o stays 0 and pc_o reads 0x102
  - rst_ni=0 clears fault_o to 0.
- Mid-WAIT reset: assert rst_ni=0 while a response is outstanding, then deliver imem_rvalid_i one cycle after reset release:
  - the word is not captured and instr_valid_o stays 0
  - the new fetch goes to RESET_PC.
- Wrap cases:
  - pc_o=32'hFFFF_FFFC acked without redirect gives next fetch address 0.
  - instret_o preset-by-sequence to 32'hFFFF_FFFF wraps to 0 on the next ack.

Source files
------------

// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage: owns the PC, fetches one word at a time
// and holds it for decode until the execute side retires it.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [6:0]  opcode_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic        instr_ack_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    output logic        fault_o,
    output logic [31:0] instret_o
);

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD,
        FAULT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    assign pc_plus4 = pc_q + 32'd4;
    assign next_pc  = redirect_i ? redirect_target_i : pc_plus4;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;
        unique case (state_q)
            BOOT: begin
                state_d = (RESET_PC[1:0] != 2'b00) ? FAULT : REQ;
            end
            REQ: begin
                if (imem_ready_i) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    instr_d = imem_rdata_i;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Redirect only matters on the retiring edge.
                if (instr_ack_i) begin
                    instr_d   = NOP_INSTR;
                    instret_d = instret_q + 32'd1;
                    pc_d      = next_pc;
                    state_d   = (next_pc[1:0] == 2'b00) ? REQ : FAULT;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    assign imem_req_o    = (state_q == REQ);
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = (state_q == HOLD);
    assign instr_o       = instr_q;
    assign opcode_o      = instr_q[6:0];
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_plus4;
    assign fault_o       = (state_q == FAULT);
    assign instret_o     = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit against a PC/retire model
// and a word-addressed instruction memory array.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [6:0]  opcode_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        instr_ack_i;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic        fault_o;
    logic [31:0] instret_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem [0:255];
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_instret;

    fetch_unit dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .imem_req_o        (imem_req_o),
        .imem_addr_o       (imem_addr_o),
        .imem_ready_i      (imem_ready_i),
        .imem_rvalid_i     (imem_rvalid_i),
        .imem_rdata_i      (imem_rdata_i),
        .instr_valid_o     (instr_valid_o),
        .instr_o           (instr_o),
        .opcode_o          (opcode_o),
        .pc_o              (pc_o),
        .pc_plus4_o        (pc_plus4_o),
        .instr_ack_i       (instr_ack_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .fault_o           (fault_o),
        .instret_o         (instret_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Fetch the word at exp_pc; starts in the first REQ cycle.
    task automatic fetch_one(input int rdy_dly, input int rv_dly);
        logic [31:0] a;
        a = exp_pc;
        check("req_on", {31'd0, imem_req_o}, 32'd1);
        check("req_addr", imem_addr_o, a);
        for (int k = 0; k < rdy_dly; k++) begin
            imem_ready_i  = 1'b0;
            imem_rvalid_i = 1'($urandom);
            imem_rdata_i  = $urandom;
            tick();
            check("stall_req", {31'd0, imem_req_o}, 32'd1);
            check("stall_addr", imem_addr_o, a);
            check("stall_valid", {31'd0, instr_valid_o}, 32'd0);
        end
        imem_ready_i  = 1'b1;
        imem_rvalid_i = 1'($urandom);
        imem_rdata_i  = $urandom;
        tick();
        imem_ready_i = 1'b0;
        check("req_drop", {31'd0, imem_req_o}, 32'd0);
        for (int k = 0; k < rv_dly; k++) begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
            tick();
            check("wait_valid", {31'd0, instr_valid_o}, 32'd0);
        end
        exp_instr     = mem[a[9:2]];
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = exp_instr;
        tick();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        check("valid", {31'd0, instr_valid_o}, 32'd1);
        check("instr", instr_o, exp_instr);
        check("opcode", {25'd0, opcode_o}, {25'd0, exp_instr[6:0]});
        check("pc", pc_o, a);
        check("pc_plus4", pc_plus4_o, a + 32'd4);
    endtask

    task automatic retire(input int hold, input bit redir,
                          input logic [31:0] tgt);
        for (int k = 0; k < hold; k++) begin
            instr_ack_i       = 1'b0;
            redirect_i        = 1'($urandom);
            redirect_target_i = $urandom;
            imem_rvalid_i     = 1'($urandom);
            imem_rdata_i      = $urandom;
            tick();
            check("hold_valid", {31'd0, instr_valid_o}, 32'd1);
            check("hold_pc", pc_o, exp_pc);
            check("hold_instr", instr_o, exp_instr);
        end
        imem_rvalid_i     = 1'b0;
        instr_ack_i       = 1'b1;
        redirect_i        = redir;
        redirect_target_i = tgt;
        tick();
        instr_ack_i = 1'b0;
        redirect_i  = 1'b0;
        exp_instret = exp_instret + 32'd1;
        exp_pc      = redir ? tgt : exp_pc + 32'd4;
        check("ack_valid", {31'd0, instr_valid_o}, 32'd0);
        check("instret", instret_o, exp_instret);
        check("ack_nop", instr_o, NOP);
        check("ack_pc", pc_o, exp_pc);
        if (exp_pc[1:0] == 2'b00) begin
            check("next_req", {31'd0, imem_req_o}, 32'd1);
            check("next_addr", imem_addr_o, exp_pc);
        end else begin
            check("fault_set", {31'd0, fault_o}, 32'd1);
        end
    endtask

    task automatic check_reset_state();
        check("rst_req", {31'd0, imem_req_o}, 32'd0);
        check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        check("rst_instr", instr_o, NOP);
        check("rst_opcode", {25'd0, opcode_o}, 32'h13);
        check("rst_pc", pc_o, 32'd0);
        check("rst_fault", {31'd0, fault_o}, 32'd0);
        check("rst_instret", instret_o, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        rst_ni            = 1'b0;
        imem_ready_i      = 1'b0;
        imem_rvalid_i     = 1'b0;
        imem_rdata_i      = 32'd0;
        instr_ack_i       = 1'b0;
        redirect_i        = 1'b0;
        redirect_target_i = 32'd0;
        exp_pc            = 32'd0;
        exp_instr         = NOP;
        exp_instret       = 32'd0;
        repeat (3) tick();
        check_reset_state();
        check("rst_pc4", pc_plus4_o, 32'd4);

        rst_ni = 1'b1;
        tick();
        fetch_one(0, 0);
        retire(0, 1'b0, 32'd0);
        fetch_one(3, 0);
        retire(0, 1'b0, 32'd0);
        fetch_one(0, 2);
        retire(0, 1'b0, 32'd0);
        fetch_one(1, 1);
        retire(0, 1'b0, 32'd0);
        check("seq_instret", instret_o, 32'd4);
        check("seq_pc", pc_o, 32'h10);

        fetch_one(0, 0);
        retire(5, 1'b1, 32'h0000_0100);
        check("redir_pc4", pc_plus4_o, 32'h104);

        for (int n = 0; n < 30; n++) begin
            bit          r;
            logic [31:0] t;
            r = 1'($urandom);
            t = {22'd0, 8'($urandom), 2'b00};
            fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            retire(int'($urandom_range(0, 3)), r, t);
        end

        fetch_one(0, 0);
        retire(0, 1'b1, 32'hFFFF_FFFC);
        fetch_one(1, 0);
        retire(1, 1'b0, 32'd0);
        check("wrap_addr", imem_addr_o, 32'd0);

        fetch_one(0, 0);
        retire(2, 1'b1, 32'h0000_0102);
        for (int k = 0; k < 20; k++) begin
            imem_ready_i  = 1'($urandom);
            imem_rvalid_i = 1'($urandom);
            instr_ack_i   = 1'($urandom);
            redirect_i    = 1'($urandom);
            tick();
            check("fault_hold", {31'd0, fault_o}, 32'd1);
            check("fault_req", {31'd0, imem_req_o}, 32'd0);
            check("fault_valid", {31'd0, instr_valid_o}, 32'd0);
            check("fault_pc", pc_o, 32'h102);
        end
        imem_ready_i  = 1'b0;
        imem_rvalid_i = 1'b0;
        instr_ack_i   = 1'b0;
        redirect_i    = 1'b0;
        rst_ni        = 1'b0;
        tick();
        exp_pc      = 32'd0;
        exp_instret = 32'd0;
        check_reset_state();

        rst_ni = 1'b1;
        tick();
        check("boot_req", {31'd0, imem_req_o}, 32'd1);
        imem_ready_i = 1'b1;
        tick();
        imem_ready_i = 1'b0;
        tick();
        rst_ni = 1'b0;
        tick();
        rst_ni        = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid_i = 1'b0;
        check("stale_valid", {31'd0, instr_valid_o}, 32'd0);
        check("stale_instr", instr_o, NOP);
        tick();
        check("stale_valid2", {31'd0, instr_valid_o}, 32'd0);
        fetch_one(0, 0);
        retire(0, 1'b0, 32'd0);
        check("post_rst_instret", instret_o, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
